// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between speculative EXE loads and committed ROB stores.
// Stores queue in an in-order buffer; loads win unless they alias a buffered store or the head store is starved.
module dmem_port_arbiter #(
  parameter int SB_DEPTH     = 4,
  parameter int TAG_W        = 6,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_resp_data,
  output logic [TAG_W-1:0] ld_resp_tag,
  input  logic             flush,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_size,
  output logic             sb_empty,
  output logic [31:0]      data_address_2DM,
  output logic [31:0]      data_write_2DM,
  output logic [1:0]       data_write_size_2DM,
  output logic             MemRead_2DM,
  output logic             MemWrite_2DM,
  input  logic [31:0]      data_read_fDM
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(SB_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_LOAD  = 2'd1,
    GNT_STORE = 2'd2
  } gnt_e;

  logic [31:0]      sb_addr_r [SB_DEPTH];
  logic [31:0]      sb_data_r [SB_DEPTH];
  logic [1:0]       sb_size_r [SB_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [SC_W-1:0]  starve_r;

  logic [SB_DEPTH-1:0] ent_hit_s;
  logic                enq_s;
  logic                deq_s;
  logic                full_s;
  logic                nonempty_s;
  logic                in_hit_s;
  logic                conflict_s;
  logic [31:0]         head_addr_s;
  logic                unused_s;
  gnt_e                gnt_s;

  assign full_s     = (count_r == FULL_CNT);
  assign nonempty_s = (count_r != {CNT_W{1'b0}});
  assign st_ready   = !full_s;
  assign sb_empty   = !nonempty_s;
  assign enq_s      = st_valid && st_ready;
  assign deq_s      = (gnt_s == GNT_STORE);
  assign unused_s   = ^ld_addr[1:0];

  // An entry is live when its distance from head is below the occupancy count.
  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off_s;
    assign off_s        = PTR_W'(i) - head_r;
    assign ent_hit_s[i] = ({1'b0, off_s} < count_r) &&
                          (sb_addr_r[i][31:2] == ld_addr[31:2]);
  end

  assign in_hit_s   = enq_s && (st_addr[31:2] == ld_addr[31:2]);
  assign conflict_s = ld_valid && ((|ent_hit_s) || in_hit_s);

  assign head_addr_s = (sb_size_r[head_r] == 2'd0) ?
                       {sb_addr_r[head_r][31:2], 2'b00} : sb_addr_r[head_r];

  // Port grant: forced store, then non-aliasing load, then any store.
  always_comb begin
    gnt_s = GNT_IDLE;
    if ((nonempty_s && (starve_r == STARVE_MAX)) || full_s) begin
      gnt_s = GNT_STORE;
    end else if (ld_valid && !conflict_s) begin
      gnt_s = GNT_LOAD;
    end else if (nonempty_s) begin
      gnt_s = GNT_STORE;
    end else begin
      gnt_s = GNT_IDLE;
    end
  end

  // DM port drive for the granted requester.
  always_comb begin
    ld_ready            = 1'b0;
    MemRead_2DM         = 1'b0;
    MemWrite_2DM        = 1'b0;
    data_address_2DM    = 32'h0000_0000;
    data_write_2DM      = 32'h0000_0000;
    data_write_size_2DM = 2'd0;
    case (gnt_s)
      GNT_LOAD: begin
        ld_ready         = 1'b1;
        MemRead_2DM      = 1'b1;
        data_address_2DM = {ld_addr[31:2], 2'b00};
      end
      GNT_STORE: begin
        MemWrite_2DM        = 1'b1;
        data_address_2DM    = head_addr_s;
        data_write_2DM      = sb_data_r[head_r];
        data_write_size_2DM = sb_size_r[head_r];
      end
      default: begin
        ld_ready = 1'b0;
      end
    endcase
  end

  // Store buffer payload; occupancy tracking makes a reset unnecessary here.
  always_ff @(posedge CLK) begin
    if (enq_s) begin
      sb_addr_r[tail_r] <= st_addr;
      sb_data_r[tail_r] <= st_data;
      sb_size_r[tail_r] <= st_size;
    end
  end

  // Pointers, occupancy and starvation counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      starve_r <= {SC_W{1'b0}};
    end else begin
      if (deq_s) head_r <= head_r + PTR_W'(1);
      if (enq_s) tail_r <= tail_r + PTR_W'(1);
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (deq_s || !nonempty_s) begin
        starve_r <= {SC_W{1'b0}};
      end else if ((gnt_s == GNT_LOAD) && (starve_r != STARVE_MAX)) begin
        starve_r <= starve_r + SC_W'(1);
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  // Load response, one cycle after the grant; flush in the grant cycle squashes it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= 32'h0000_0000;
      ld_resp_tag   <= {TAG_W{1'b0}};
    end else if (gnt_s == GNT_LOAD) begin
      ld_resp_valid <= !flush;
      ld_resp_data  <= data_read_fDM;
      ld_resp_tag   <= ld_tag;
    end else begin
      ld_resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: loads, store drain, aliasing, starvation, flush and reset.
module tb_dmem_port_arbiter;

  logic        CLK;
  logic        RESET;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [5:0]  ld_tag;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [5:0]  ld_resp_tag;
  logic        flush;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        sb_empty;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;

  int total = 0;
  int bad   = 0;

  dmem_port_arbiter #(.SB_DEPTH(4), .TAG_W(6), .STARVE_LIMIT(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag),
    .flush(flush),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .sb_empty(sb_empty),
    .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
    .data_write_size_2DM(data_write_size_2DM),
    .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
    .data_read_fDM(data_read_fDM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s);
    chk({tag, "_wr"},   32'(MemWrite_2DM), 32'd1);
    chk({tag, "_rd"},   32'(MemRead_2DM), 32'd0);
    chk({tag, "_addr"}, data_address_2DM, a);
    chk({tag, "_data"}, data_write_2DM, d);
    chk({tag, "_size"}, 32'(data_write_size_2DM), 32'(s));
  endtask

  initial begin
    RESET = 1'b1; ld_valid = 1'b0; ld_addr = 32'h0; ld_tag = 6'h0; flush = 1'b0;
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'd0; data_read_fDM = 32'h0;
    #1;
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_stready", 32'(st_ready), 32'd1);
    chk("rst_respv", 32'(ld_resp_valid), 32'd0);
    tick(); tick();
    RESET = 1'b0;

    // idle
    #1;
    chk("idle_rd", 32'(MemRead_2DM), 32'd0);
    chk("idle_wr", 32'(MemWrite_2DM), 32'd0);
    chk("idle_addr", data_address_2DM, 32'h0);
    chk("idle_wdata", data_write_2DM, 32'h0);
    tick();
    chk("idle_respv", 32'(ld_resp_valid), 32'd0);
    chk("idle_empty", 32'(sb_empty), 32'd1);

    // single load
    ld_valid = 1'b1; ld_addr = 32'h0000_1006; ld_tag = 6'h15; data_read_fDM = 32'hDEAD_BEEF;
    #1;
    chk("ld_ready", 32'(ld_ready), 32'd1);
    chk("ld_rd", 32'(MemRead_2DM), 32'd1);
    chk("ld_addr", data_address_2DM, 32'h0000_1004);
    tick();
    ld_valid = 1'b0;
    chk("ld_respv", 32'(ld_resp_valid), 32'd1);
    chk("ld_respd", ld_resp_data, 32'hDEAD_BEEF);
    chk("ld_respt", 32'(ld_resp_tag), 32'h15);
    tick();
    chk("ld_resp_drop", 32'(ld_resp_valid), 32'd0);

    // fill the buffer while loads win, then drain in order
    ld_valid = 1'b1; ld_addr = 32'h0000_4000; ld_tag = 6'h01; data_read_fDM = 32'hA5A5_0001;
    st_valid = 1'b1; st_addr = 32'h0000_3002; st_data = 32'h1111_1111; st_size = 2'd0;
    #1; chk("fillA_ld", 32'(ld_ready), 32'd1); chk("fillA_st", 32'(st_ready), 32'd1);
    tick();
    st_addr = 32'h0000_3005; st_data = 32'h2222_2222; st_size = 2'd1;
    #1; chk("fillB_ld", 32'(ld_ready), 32'd1);
    tick();
    st_addr = 32'h0000_300A; st_data = 32'h3333_3333; st_size = 2'd2;
    #1; chk("fillC_ld", 32'(ld_ready), 32'd1);
    tick();
    st_addr = 32'h0000_300D; st_data = 32'h4444_4444; st_size = 2'd3;
    #1; chk("fillD_ld", 32'(ld_ready), 32'd1); chk("fillD_st", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("full_stready", 32'(st_ready), 32'd0);
    chk("full_ldready", 32'(ld_ready), 32'd0);
    chk_store("drain0", 32'h0000_3000, 32'h1111_1111, 2'd0);
    tick();
    ld_valid = 1'b0;
    chk("drain_respv", 32'(ld_resp_valid), 32'd0);
    #1;
    chk("drain1_stready", 32'(st_ready), 32'd1);
    chk_store("drain1", 32'h0000_3005, 32'h2222_2222, 2'd1);
    tick();
    chk_store("drain2", 32'h0000_300A, 32'h3333_3333, 2'd2);
    tick();
    chk("drain3_empty", 32'(sb_empty), 32'd0);
    chk_store("drain3", 32'h0000_300D, 32'h4444_4444, 2'd3);
    tick();
    chk("drained_empty", 32'(sb_empty), 32'd1);
    chk("drained_wr", 32'(MemWrite_2DM), 32'd0);

    // aliasing load waits for the store to 0x2000
    st_valid = 1'b1; st_addr = 32'h0000_2000; st_data = 32'h0000_0055; st_size = 2'd0;
    ld_valid = 1'b1; ld_addr = 32'h0000_2002; ld_tag = 6'h07; data_read_fDM = 32'h1234_5678;
    #1;
    chk("alias0_ld", 32'(ld_ready), 32'd0);
    chk("alias0_rd", 32'(MemRead_2DM), 32'd0);
    chk("alias0_wr", 32'(MemWrite_2DM), 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("alias1_ld", 32'(ld_ready), 32'd0);
    chk_store("alias1", 32'h0000_2000, 32'h0000_0055, 2'd0);
    tick();
    chk("alias2_ld", 32'(ld_ready), 32'd1);
    chk("alias2_addr", data_address_2DM, 32'h0000_2000);
    tick();
    ld_valid = 1'b0;
    chk("alias_respv", 32'(ld_resp_valid), 32'd1);
    chk("alias_respd", ld_resp_data, 32'h1234_5678);
    chk("alias_respt", 32'(ld_resp_tag), 32'h07);

    // starvation: one buffered store, continuous non-aliasing loads
    st_valid = 1'b1; st_addr = 32'h0000_5000; st_data = 32'h0000_0066; st_size = 2'd0;
    ld_valid = 1'b1; ld_addr = 32'h0000_6000; ld_tag = 6'h0C; data_read_fDM = 32'hCAFE_0000;
    #1; chk("starve_enq_ld", 32'(ld_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("starve_ld%0d", i), 32'(ld_ready), 32'd1);
      chk($sformatf("starve_nowr%0d", i), 32'(MemWrite_2DM), 32'd0);
      tick();
    end
    chk("starve_forced_ld", 32'(ld_ready), 32'd0);
    chk_store("starve_forced", 32'h0000_5000, 32'h0000_0066, 2'd0);
    tick();
    chk("starve_after_respv", 32'(ld_resp_valid), 32'd0);
    chk("starve_after_ld", 32'(ld_ready), 32'd1);
    chk("starve_after_empty", 32'(sb_empty), 32'd1);
    tick();

    // flush in the grant cycle suppresses the response
    ld_addr = 32'h0000_7000; ld_tag = 6'h2A; flush = 1'b1; data_read_fDM = 32'h9999_9999;
    #1; chk("flush_ldready", 32'(ld_ready), 32'd1);
    tick();
    chk("flush_respv", 32'(ld_resp_valid), 32'd0);
    flush = 1'b0; ld_tag = 6'h2B; data_read_fDM = 32'h7777_7777;
    tick();
    ld_valid = 1'b0; flush = 1'b1;
    #1;
    chk("lateflush_respv", 32'(ld_resp_valid), 32'd1);
    chk("lateflush_respt", 32'(ld_resp_tag), 32'h2B);
    chk("lateflush_respd", ld_resp_data, 32'h7777_7777);
    flush = 1'b0;
    tick();

    // reset while two stores are buffered
    st_valid = 1'b1; st_addr = 32'h0000_8000; st_data = 32'h0000_0088; st_size = 2'd0;
    ld_valid = 1'b1; ld_addr = 32'h0000_9000; ld_tag = 6'h33;
    tick();
    st_addr = 32'h0000_8004;
    tick();
    st_valid = 1'b0; ld_valid = 1'b0;
    #1;
    chk("pre_rst_empty", 32'(sb_empty), 32'd0);
    chk("pre_rst_respv", 32'(ld_resp_valid), 32'd1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(sb_empty), 32'd1);
    chk("mid_rst_stready", 32'(st_ready), 32'd1);
    chk("mid_rst_wr", 32'(MemWrite_2DM), 32'd0);
    chk("mid_rst_respv", 32'(ld_resp_valid), 32'd0);
    chk("mid_rst_respt", 32'(ld_resp_tag), 32'h0);
    chk("mid_rst_respd", ld_resp_data, 32'h0);
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_rst_wr%0d", i), 32'(MemWrite_2DM), 32'd0);
      chk($sformatf("post_rst_empty%0d", i), 32'(sb_empty), 32'd1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
